// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event classifier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package button_event_pkg;

  // Width of the saturating phase counter (and the optional repeat counter).
  localparam int unsigned CTR_W = 32;

  // Classifier states: idle, first press held, long hold, waiting for a second
  // press after a short release, second press held.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    WAIT_DBL  = 3'd3,
    SECOND    = 3'd4
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] i_val);
    return (i_val == {CTR_W{1'b1}}) ? i_val : i_val + 1'b1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising/falling edge detector on the debounced button level.
// Latency: edges are combinational against the level registered at the previous edge.
// Backpressure: none; the level is sampled every clock.
module edge_detect (
  input  logic iCLK,
  input  logic iRESET,
  input  logic iSIG,
  output logic oRISE,
  output logic oFALL
);

  logic r_sig_d;

  // Previous-cycle level; cleared by reset so a button held through reset
  // reads as a fresh rising edge once reset lifts.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= iSIG;
    end
  end

  assign oRISE = iSIG & ~r_sig_d;
  assign oFALL = ~iSIG & r_sig_d;

endmodule

// File: rtl/button_event.sv
// Classifies a debounced button level into press/release/short/long/double pulses.
// Latency: every output is a registered one-cycle pulse in the cycle after its deciding edge.
// Backpressure: none; pulses are fire-and-forget. Optional auto-repeat: BUTTON_EVENT_REPEAT_EN.
module button_event
  import button_event_pkg::*;
#(
  parameter logic [31:0] pLONG_CLKS   = 32'd50_000_000,
  parameter logic [31:0] pDBL_CLKS    = 32'd15_000_000,
  parameter logic [31:0] pREPEAT_CLKS = 32'd10_000_000
) (
  input  logic iCLK,
  input  logic iRESET,
  input  logic iSIG,
  output logic oPRESS,
  output logic oRELEASE,
  output logic oSHORT,
  output logic oLONG,
  output logic oDOUBLE,
  output logic oREPEAT
);

  // The counter reads k-1 at the k-th edge after a transition, so a window of
  // N clocks closes when the counter holds N-1.
  localparam logic [CTR_W-1:0] LONG_LAST = pLONG_CLKS - 32'd1;
  localparam logic [CTR_W-1:0] DBL_LAST  = pDBL_CLKS - 32'd1;

  logic             w_rise;
  logic             w_fall;
  logic             w_long_hit;
  logic             w_dbl_hit;

  state_t           r_state;
  logic [CTR_W-1:0] r_cnt;
  logic             r_press;
  logic             r_release;
  logic             r_short;
  logic             r_long;
  logic             r_double;

  edge_detect u_edge_detect (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iSIG   (iSIG),
    .oRISE  (w_rise),
    .oFALL  (w_fall)
  );

  assign w_long_hit = (r_cnt == LONG_LAST);
  assign w_dbl_hit  = (r_cnt == DBL_LAST);

  // Classifier FSM: the counter free-runs (saturating) and is cleared on every
  // state change. A release always beats a long timeout on the same edge, and a
  // second press beats the short-click timeout on the same edge.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_double  <= 1'b0;
    end else begin
      r_press   <= w_rise;
      r_release <= w_fall;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_double  <= 1'b0;
      r_cnt     <= sat_inc(r_cnt);

      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end
        end

        PRESSED: begin
          if (w_fall) begin
            r_state <= WAIT_DBL;
            r_cnt   <= '0;
          end else if (w_long_hit) begin
            r_long  <= 1'b1;
            r_state <= LONG_HELD;
            r_cnt   <= '0;
          end
        end

        LONG_HELD: begin
          if (w_fall) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        end

        WAIT_DBL: begin
          if (w_rise) begin
            r_state <= SECOND;
            r_cnt   <= '0;
          end else if (w_dbl_hit) begin
            r_short <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        end

        SECOND: begin
          if (w_fall) begin
            r_double <= 1'b1;
            r_state  <= IDLE;
            r_cnt    <= '0;
          end else if (w_long_hit) begin
            r_long  <= 1'b1;
            r_state <= LONG_HELD;
            r_cnt   <= '0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign oPRESS   = r_press;
  assign oRELEASE = r_release;
  assign oSHORT   = r_short;
  assign oLONG    = r_long;
  assign oDOUBLE  = r_double;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CTR_W-1:0] REP_LAST = pREPEAT_CLKS - 32'd1;

  logic [CTR_W-1:0] r_rep_cnt;
  logic             r_repeat;

  // Auto-repeat: counts only while the long hold continues; it is zero on the
  // edge that enters LONG_HELD, so the first repeat lands pREPEAT_CLKS after
  // oLONG. A release on a repeat edge suppresses that repeat.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_rep_cnt <= '0;
      r_repeat  <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if ((r_state == LONG_HELD) && !w_fall) begin
        if (r_rep_cnt == REP_LAST) begin
          r_repeat  <= 1'b1;
          r_rep_cnt <= '0;
        end else begin
          r_rep_cnt <= r_rep_cnt + 1'b1;
        end
      end else begin
        r_rep_cnt <= '0;
      end
    end
  end

  assign oREPEAT = r_repeat;
`else
  // Repeat period only matters when auto-repeat is built in.
  logic w_unused_repeat;
  assign w_unused_repeat = ^pREPEAT_CLKS;
  assign oREPEAT         = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event against a timestamp-based event model.
module tb_button_event;

  localparam int LONG = 8;
  localparam int DBL  = 5;
  localparam int REP  = 3;

  logic iCLK = 1'b0;
  logic iRESET = 1'b1;
  logic iSIG = 1'b0;
  logic oPRESS, oRELEASE, oSHORT, oLONG, oDOUBLE, oREPEAT;

  always #5 iCLK = ~iCLK;

  button_event #(
    .pLONG_CLKS   (32'd8),
    .pDBL_CLKS    (32'd5),
    .pREPEAT_CLKS (32'd3)
  ) dut (
    .iCLK     (iCLK),
    .iRESET   (iRESET),
    .iSIG     (iSIG),
    .oPRESS   (oPRESS),
    .oRELEASE (oRELEASE),
    .oSHORT   (oSHORT),
    .oLONG    (oLONG),
    .oDOUBLE  (oDOUBLE),
    .oREPEAT  (oREPEAT)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: remembers when things happened rather than which state
  // it is in. A press is "second" if it arrives while a short click is still
  // waiting for its window to close.
  bit m_prev, m_in_press, m_second, m_long_fired, m_pending;
  int m_tp, m_trel, m_tlong;
  bit e_press, e_release, e_short, e_long, e_double, e_repeat;
  int n_short_seen;

  task automatic model_edge(input logic r, input logic s);
    bit rise, fall;
    e_press = 0; e_release = 0; e_short = 0; e_long = 0; e_double = 0; e_repeat = 0;
    if (r) begin
      m_prev = 0; m_in_press = 0; m_second = 0; m_long_fired = 0; m_pending = 0;
      return;
    end
    rise = s && !m_prev;
    fall = !s && m_prev;
    e_press   = rise;
    e_release = fall;
    if (rise) begin
      m_second     = m_pending;
      m_pending    = 0;
      m_in_press   = 1;
      m_tp         = cyc;
      m_long_fired = 0;
    end
    if (m_pending && (cyc - m_trel == DBL)) begin
      e_short   = 1;
      m_pending = 0;
    end
    if (m_in_press && s && !m_long_fired && (cyc - m_tp == LONG)) begin
      e_long       = 1;
      m_long_fired = 1;
      m_tlong      = cyc;
    end
    if (m_in_press && s && m_long_fired && (cyc > m_tlong) && ((cyc - m_tlong) % REP == 0))
      e_repeat = 1;
    if (fall && m_in_press) begin
      m_in_press = 0;
      if (!m_long_fired) begin
        if (m_second) e_double = 1;
        else begin
          m_pending = 1;
          m_trel    = cyc;
        end
      end
    end
    m_prev = s;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive at the falling edge, model the rising edge, check #1 later.
  task automatic step(input logic r, input logic s);
    logic exp_rep;
    @(negedge iCLK);
    iRESET = r;
    iSIG   = s;
    @(posedge iCLK);
    model_edge(r, s);
    cyc++;
    #1;
`ifdef BUTTON_EVENT_REPEAT_EN
    exp_rep = e_repeat;
`else
    exp_rep = 1'b0;
`endif
    check("press",   oPRESS,   e_press);
    check("release", oRELEASE, e_release);
    check("short",   oSHORT,   e_short);
    check("long",    oLONG,    e_long);
    check("double",  oDOUBLE,  e_double);
    check("repeat",  oREPEAT,  exp_rep);
    check("one_class_event", ((32'(oSHORT) + 32'(oLONG) + 32'(oDOUBLE)) <= 1), 1'b1);
    if (oSHORT === 1'b1) n_short_seen++;
  endtask

  task automatic hold(input logic s, input int n);
    for (int k = 0; k < n; k++) step(1'b0, s);
  endtask

  initial begin
    int len;
    logic lvl;

    // Reset held with the button down, then a press right after release of reset.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    hold(1'b1, 2);
    hold(1'b0, 10);

    // Short click.
    hold(1'b1, 3);
    hold(1'b0, 10);

    // Long press with repeat window.
    hold(1'b1, 12);
    hold(1'b0, 10);

    // Long boundary: exactly the threshold is short, one more is long.
    hold(1'b1, 8);
    hold(1'b0, 10);
    hold(1'b1, 9);
    hold(1'b0, 10);

    // Double click with second rise at tr+5, then a miss at tr+6.
    hold(1'b1, 3);
    hold(1'b0, 5);
    hold(1'b1, 2);
    hold(1'b0, 10);
    hold(1'b1, 3);
    hold(1'b0, 6);
    hold(1'b1, 2);
    hold(1'b0, 10);

    // Second press held long: long instead of double.
    hold(1'b1, 2);
    hold(1'b0, 1);
    hold(1'b1, 11);
    hold(1'b0, 8);

    // Reset during the double-click wait abandons the pending short.
    hold(1'b1, 3);
    hold(1'b0, 2);
    n_short_seen = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    hold(1'b0, 12);
    check("no_short_after_reset", (n_short_seen == 0), 1'b1);

    // Randomised runs of levels with the occasional reset.
    for (int seg = 0; seg < 120; seg++) begin
      len = $urandom_range(1, 14);
      lvl = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 29) == 0) begin
        step(1'b1, lvl);
        len = len - 1;
      end
      hold(lvl, len);
    end
    hold(1'b0, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the debouncer and consumes its clean, stable level output.
- Classifies button activity into single-cycle event pulses: press, release, short-click, long-press and double-click.
- Feeds UI/control logic, so consumers never need their own timers or edge detectors.

Parameters:
pLONG_CLKS, 32'd50_000_000, hold duration in clocks that qualifies a long press; must be >= 2.
pDBL_CLKS, 32'd15_000_000, window in clocks after a short release during which a second press makes a double-click; must be >= 1.
pREPEAT_CLKS, 32'd10_000_000, auto-repeat period in clocks; used only with the optional feature.

Ports:
iCLK  input  1  single clock.
iRESET  input  1  synchronous, active-high reset.
iSIG  input  1  debounced button level; 1 = pressed.
oPRESS  output  1  one-cycle pulse on every rising edge of iSIG.
oRELEASE  output  1  one-cycle pulse on every falling edge of iSIG.
oSHORT  output  1  one-cycle pulse: single short click confirmed.
oLONG  output  1  one-cycle pulse: hold reached pLONG_CLKS.
oDOUBLE  output  1  one-cycle pulse: double-click confirmed.
oREPEAT  output  1  one-cycle auto-repeat pulse while long-held; constant 0 without the feature.

Behaviour:
- Timing convention: "pulse at edge E" means the registered output is 1 for exactly the one cycle following clock edge E.
- Reset state: all outputs 0, FSM in IDLE, counter 0, previous-level register sig_d 0. A button held through reset therefore gives oPRESS at the first edge after iRESET deasserts.
- Reset mid-operation: abandons any pending event; nothing is emitted for it.
- Edge detect:
  - t0 = first edge sampling iSIG=1 with sig_d=0; oPRESS pulses at t0.
  - tr = first edge sampling iSIG=0 with sig_d=1; oRELEASE pulses at tr.
  - oPRESS and oRELEASE fire in every FSM state.
- Counter: pCTR bits = 32, saturating, cleared on every FSM transition, otherwise +1 per clock.
- IDLE:
  - rise -> PRESSED.
- PRESSED, duration D = edges since t0:
  - iSIG still 1 at t0+pLONG_CLKS -> oLONG pulses at that edge, go to LONG_HELD.
  - Fall at tr with tr-t0 <= pLONG_CLKS -> WAIT_DBL. The equal case is short, because the release wins.
- LONG_HELD:
  - fall -> IDLE; no oSHORT and no oDOUBLE.
- WAIT_DBL, with tr = the release edge:
  - rise sampled at any edge tr+1 .. tr+pDBL_CLKS -> SECOND. At edge tr+pDBL_CLKS the press wins and no oSHORT is emitted.
  - iSIG still 0 at tr+pDBL_CLKS -> oSHORT pulses at that edge, go to IDLE.
- SECOND, with tp = the second press edge:
  - fall before tp+pLONG_CLKS -> oDOUBLE pulses at the fall edge, go to IDLE.
  - iSIG still 1 at tp+pLONG_CLKS -> oLONG pulses, go to LONG_HELD; no oDOUBLE, no oSHORT.
- Coincidence: at most one of oSHORT/oLONG/oDOUBLE per edge. oPRESS/oRELEASE may coincide with oDOUBLE or oLONG logic as specified above.
- A press after an oSHORT is a fresh t0.

Optional Feature:
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined: in LONG_HELD, oREPEAT pulses every pREPEAT_CLKS clocks after the oLONG edge, at oLONG+pREPEAT_CLKS, +2*pREPEAT_CLKS, and so on, until fall or reset. The repeat counter is separate and cleared on entry to LONG_HELD.
- Undefined: oREPEAT is tied to 0, no repeat counter is synthesized, and pREPEAT_CLKS is ignored.

Decomposition:
- Package button_event_pkg holds:
  - the FSM state typedef/encoding (IDLE, PRESSED, LONG_HELD, WAIT_DBL, SECOND);
  - the counter width constant (32).
- Sub-module edge_detect (iCLK, iRESET, iSIG -> oRISE, oFALL): registered sig_d and combinational rise/fall, instantiated once.

Test Plan:
All scenarios use pLONG_CLKS=8, pDBL_CLKS=5, pREPEAT_CLKS=3.
1. iRESET high for 3 clocks with iSIG=1, then release reset -> all outputs 0 during reset; oPRESS at the first edge after reset.
2. Short click, iSIG=1 for D=3 -> oPRESS@t0, oRELEASE@t0+3, oSHORT@t0+8; no oLONG/oDOUBLE.
3. Long press, D=12 -> oLONG@t0+8, oRELEASE@t0+12; no oSHORT. With BUTTON_EVENT_REPEAT_EN: oREPEAT@t0+11; without it, oREPEAT stays 0.
4. Long boundary:
   - D=8 -> short path, oSHORT@t0+13.
   - D=9 -> oLONG@t0+8.
5. Double click, high 3, low until a rise at tr+5, high 2 -> oDOUBLE at the second fall; no oSHORT. Repeat with the second rise at tr+6 -> oSHORT@tr+5, then a fresh press at tr+6.
6. Reset asserted at tr+2 in WAIT_DBL -> no oSHORT ever emitted; FSM in IDLE, outputs 0.
